// File: rtl/ecc_secded_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module : ecc_secded_dec_pipe
// SECDED (Hsiao) decoder with ready/valid pipeline, error counters and log.
// Rev    : 1.0  initial release
// ============================================================================
module ecc_secded_dec_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7,
  parameter logic [DATA_W*CHK_W-1:0] H_COLS = {
    7'h34, 7'h62, 7'h61, 7'h58, 7'h54, 7'h52, 7'h51, 7'h4C,
    7'h4A, 7'h49, 7'h46, 7'h45, 7'h43, 7'h38, 7'h32, 7'h31,
    7'h2C, 7'h2A, 7'h29, 7'h26, 7'h25, 7'h23, 7'h1C, 7'h1A,
    7'h19, 7'h16, 7'h15, 7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h07},
  parameter int PIPE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W+CHK_W:0]  in_word,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   corr_en,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_tag,
  output logic [CHK_W-1:0]       out_syn,
  output logic                   out_sec,
  output logic                   out_ded,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       sec_cnt,
  output logic [CNT_W-1:0]       ded_cnt,
  input  logic                   log_clr,
  output logic                   log_valid,
  output logic [CHK_W-1:0]       log_syn,
  output logic                   log_ded,
  output logic [DATA_W+CHK_W:0]  log_word
);

  localparam int WORD_W = DATA_W + CHK_W + 1;

  function automatic logic [CHK_W-1:0] f_syn(input logic [DATA_W+CHK_W-1:0] cw);
    logic [CHK_W-1:0] s;
    s = cw[DATA_W +: CHK_W];
    for (int i = 0; i < DATA_W; i++) begin
      if (cw[i]) s = s ^ H_COLS[i*CHK_W +: CHK_W];
    end
    return s;
  endfunction

  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_data_q;
  logic                 out_tag_q;
  logic [CHK_W-1:0]     out_syn_q;
  logic                 out_sec_q;
  logic                 out_ded_q;
  logic [WORD_W-1:0]    out_raw_q;
  logic                 w_out_load;
  logic                 w_out_fire;

  logic                 w_up_valid;
  logic [WORD_W-1:0]    w_up_word;
  logic                 w_up_corr;
  logic [CHK_W-1:0]     w_up_syn;

  assign w_out_load = ~out_valid_q | out_ready;
  assign w_out_fire = out_valid_q & out_ready;

  generate
    if (PIPE != 0) begin : g_syn_stage
      logic              s1_valid_q;
      logic [WORD_W-1:0] s1_word_q;
      logic              s1_corr_q;
      logic [CHK_W-1:0]  s1_syn_q;
      logic              w_s1_load;

      assign w_s1_load = ~s1_valid_q | w_out_load;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_word_q  <= '0;
          s1_corr_q  <= 1'b0;
          s1_syn_q   <= '0;
        end else if (w_s1_load) begin
          s1_valid_q <= in_valid;
          if (in_valid) begin
            s1_word_q <= in_word;
            s1_corr_q <= corr_en;
            s1_syn_q  <= f_syn(in_word[DATA_W+CHK_W-1:0]);
          end
        end
      end

      assign in_ready   = ~rst & w_s1_load;
      assign w_up_valid = s1_valid_q;
      assign w_up_word  = s1_word_q;
      assign w_up_corr  = s1_corr_q;
      assign w_up_syn   = s1_syn_q;
    end else begin : g_no_syn_stage
      assign in_ready   = ~rst & w_out_load;
      assign w_up_valid = in_valid;
      assign w_up_word  = in_word;
      assign w_up_corr  = corr_en;
      assign w_up_syn   = f_syn(in_word[DATA_W+CHK_W-1:0]);
    end
  endgenerate

  // Hsiao columns are distinct, so at most one data bit can match the syndrome.
  logic [DATA_W-1:0] w_flip;
  logic              w_sec;
  logic              w_ded;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    w_flip = '0;
    w_sec  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (w_up_syn == H_COLS[i*CHK_W +: CHK_W]) begin
        w_flip[i] = 1'b1;
        w_sec     = 1'b1;
      end
    end
    if ((w_up_syn != '0) && ((w_up_syn & (w_up_syn - CHK_W'(1))) == '0)) w_sec = 1'b1;
    w_ded  = (w_up_syn != '0) & ~w_sec;
    w_data = w_up_word[DATA_W-1:0] ^ (w_up_corr ? w_flip : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= 1'b0;
      out_syn_q   <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_raw_q   <= '0;
    end else if (w_out_load) begin
      out_valid_q <= w_up_valid;
      if (w_up_valid) begin
        out_data_q <= w_data;
        out_tag_q  <= w_up_word[WORD_W-1];
        out_syn_q  <= w_up_syn;
        out_sec_q  <= w_sec;
        out_ded_q  <= w_ded;
        out_raw_q  <= w_up_word;
      end
    end
  end

  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  logic              log_valid_q, log_valid_d;
  logic [CHK_W-1:0]  log_syn_q, log_syn_d;
  logic              log_ded_q, log_ded_d;
  logic [WORD_W-1:0] log_word_q, log_word_d;

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (w_out_fire) begin
      if (out_sec_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (out_ded_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  // A clear in the same cycle as an error still records that error.
  always_comb begin
    log_valid_d = log_valid_q & ~log_clr;
    log_syn_d   = log_syn_q;
    log_ded_d   = log_ded_q;
    log_word_d  = log_word_q;
    if (w_out_fire && (out_sec_q | out_ded_q) && (~log_valid_q | log_clr)) begin
      log_valid_d = 1'b1;
      log_syn_d   = out_syn_q;
      log_ded_d   = out_ded_q;
      log_word_d  = out_raw_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
      log_valid_q <= 1'b0;
      log_syn_q   <= '0;
      log_ded_q   <= 1'b0;
      log_word_q  <= '0;
    end else begin
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
      log_valid_q <= log_valid_d;
      log_syn_q   <= log_syn_d;
      log_ded_q   <= log_ded_d;
      log_word_q  <= log_word_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_syn   = out_syn_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;
  assign log_valid = log_valid_q;
  assign log_syn   = log_syn_q;
  assign log_ded   = log_ded_q;
  assign log_word  = log_word_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_ecc_secded_dec_pipe
// Bench for the SECDED decoder: default build (A) and PIPE=1/CNT_W=2 build (B).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ecc_secded_dec_pipe;

  localparam logic [6:0] HCOL [32] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49, 7'h4A,
    7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62, 7'h34};

  typedef struct packed {
    logic [31:0] data;
    logic        tag;
    logic [6:0]  syn;
    logic        sec;
    logic        ded;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        corr_en = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic        log_clr = 1'b0;
  logic [39:0] in_word = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        a_in_ready, a_tag, a_sec, a_ded, a_valid, a_log_valid, a_log_ded;
  logic [31:0] a_data;
  logic [6:0]  a_syn, a_log_syn;
  logic [15:0] a_sec_cnt, a_ded_cnt;
  logic [39:0] a_log_word;
  logic        b_in_ready, b_tag, b_sec, b_ded, b_valid, b_log_valid, b_log_ded;
  logic [31:0] b_data;
  logic [6:0]  b_syn, b_log_syn;
  logic [1:0]  b_sec_cnt, b_ded_cnt;
  logic [39:0] b_log_word;

  logic        o_in_ready, o_tag, o_sec, o_ded, o_valid, o_log_valid, o_log_ded;
  logic [31:0] o_data;
  logic [6:0]  o_syn, o_log_syn;
  logic [15:0] o_sec_cnt, o_ded_cnt;
  logic [39:0] o_log_word;

  always #5 clk = ~clk;

  ecc_secded_dec_pipe u_dut_a (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid & ~sel),
    .in_ready(a_in_ready), .corr_en(corr_en), .out_data(a_data), .out_tag(a_tag),
    .out_syn(a_syn), .out_sec(a_sec), .out_ded(a_ded), .out_valid(a_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .sec_cnt(a_sec_cnt), .ded_cnt(a_ded_cnt),
    .log_clr(log_clr), .log_valid(a_log_valid), .log_syn(a_log_syn),
    .log_ded(a_log_ded), .log_word(a_log_word));

  ecc_secded_dec_pipe #(.PIPE(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid & sel),
    .in_ready(b_in_ready), .corr_en(corr_en), .out_data(b_data), .out_tag(b_tag),
    .out_syn(b_syn), .out_sec(b_sec), .out_ded(b_ded), .out_valid(b_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .sec_cnt(b_sec_cnt), .ded_cnt(b_ded_cnt),
    .log_clr(log_clr), .log_valid(b_log_valid), .log_syn(b_log_syn),
    .log_ded(b_log_ded), .log_word(b_log_word));

  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_data      = sel ? b_data      : a_data;
  assign o_tag       = sel ? b_tag       : a_tag;
  assign o_syn       = sel ? b_syn       : a_syn;
  assign o_sec       = sel ? b_sec       : a_sec;
  assign o_ded       = sel ? b_ded       : a_ded;
  assign o_valid     = sel ? b_valid     : a_valid;
  assign o_sec_cnt   = sel ? {14'd0, b_sec_cnt} : a_sec_cnt;
  assign o_ded_cnt   = sel ? {14'd0, b_ded_cnt} : a_ded_cnt;
  assign o_log_valid = sel ? b_log_valid : a_log_valid;
  assign o_log_syn   = sel ? b_log_syn   : a_log_syn;
  assign o_log_ded   = sel ? b_log_ded   : a_log_ded;
  assign o_log_word  = sel ? b_log_word  : a_log_word;

  // Reference: syndrome from per-row parity masks, classification by column search.
  function automatic exp_t model(input logic [39:0] w, input logic corr);
    exp_t        e;
    logic [31:0] rowm;
    logic [6:0]  col;
    e.data = w[31:0];
    e.tag  = w[39];
    for (int k = 0; k < 7; k++) begin
      rowm = '0;
      for (int i = 0; i < 32; i++) begin
        col = HCOL[i];
        rowm[i] = col[k];
      end
      e.syn[k] = (^(w[31:0] & rowm)) ^ w[32+k];
    end
    e.sec = 1'b0;
    e.ded = 1'b0;
    if (e.syn != 7'd0) begin
      if ($countones(e.syn) == 1) e.sec = 1'b1;
      else begin
        e.ded = 1'b1;
        for (int i = 0; i < 32; i++) begin
          if (HCOL[i] == e.syn) begin
            e.sec = 1'b1;
            e.ded = 1'b0;
            if (corr) e.data[i] = ~e.data[i];
          end
        end
      end
    end
    return e;
  endfunction

  function automatic logic [6:0] enc(input logic [31:0] d);
    exp_t e;
    e = model({8'h00, d}, 1'b0);
    return e.syn;
  endfunction

  function automatic logic [39:0] rand_word();
    logic [31:0] d;
    logic [39:0] w;
    int nf, b1, b2;
    d  = $urandom;
    w  = {1'b0, enc(d), d};
    w[39] = ($urandom_range(0, 1) != 0);
    nf = $urandom_range(0, 2);
    b1 = $urandom_range(0, 38);
    b2 = (b1 + $urandom_range(1, 38)) % 39;
    if (nf >= 1) w[b1] = ~w[b1];
    if (nf == 2) w[b2] = ~w[b2];
    return w;
  endfunction

  task automatic send(input logic [39:0] w, input logic c);
    int t;
    t = 0;
    in_word = w; corr_en = c; in_valid = 1'b1;
    @(negedge clk);
    while (!o_in_ready && t < 20) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 20) $display("FAIL send_timeout: in_ready stayed %b, required 1", o_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!o_valid && lat < 10) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_word  = 40'hFF_FFFF_FFFF;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_checks++;
      if ({o_valid, o_in_ready, o_data, o_tag, o_syn, o_sec, o_ded, o_sec_cnt, o_ded_cnt,
           o_log_valid, o_log_syn, o_log_ded, o_log_word} !== '0)
        $display("FAIL reset_state sel=%0d: valid=%b rdy=%b data=%h cnt=%h/%h log=%b, required all 0",
                 s, o_valid, o_in_ready, o_data, o_sec_cnt, o_ded_cnt, o_log_valid);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_checks++;
      if ({o_in_ready, o_valid} !== 2'b10)
        $display("FAIL reset_release sel=%0d: in_ready=%b out_valid=%b, required 1/0", s, o_in_ready, o_valid);
      else n_pass++;
    end
    sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    int lat;
    sel = 1'b0;
    send(40'h0, 1'b1);
    wait_out(lat);
    n_checks++;
    if (lat != 1) $display("FAIL clean_latency: got %0d cycles, required 1", lat);
    else n_pass++;
    n_checks++;
    if ({o_data, o_syn, o_sec, o_ded} !== {32'h0, 7'h00, 2'b00})
      $display("FAIL clean_word: data=%h syn=%h sec=%b ded=%b, required 0/0/0/0", o_data, o_syn, o_sec, o_ded);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat;
    send(40'h1, 1'b1);
    wait_out(lat);
    n_checks++;
    if ({o_data, o_syn, o_sec, o_ded} !== {32'h0, 7'h07, 2'b10})
      $display("FAIL single_bit0: data=%h syn=%h sec=%b ded=%b, required 0/07/1/0", o_data, o_syn, o_sec, o_ded);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({o_sec_cnt, o_log_valid, o_log_syn, o_log_ded, o_log_word} !== {16'd1, 1'b1, 7'h07, 1'b0, 40'h1})
      $display("FAIL single_cnt_log: sec_cnt=%0d log_valid=%b log_syn=%h log_ded=%b log_word=%h, required 1/1/07/0/1",
               o_sec_cnt, o_log_valid, o_log_syn, o_log_ded, o_log_word);
    else n_pass++;
  endtask

  task automatic test_double();
    int lat;
    send(40'h3, 1'b1);
    wait_out(lat);
    n_checks++;
    if ({o_data, o_syn, o_sec, o_ded} !== {32'h3, 7'h0C, 2'b01})
      $display("FAIL double_bit01: data=%h syn=%h sec=%b ded=%b, required 3/0C/0/1", o_data, o_syn, o_sec, o_ded);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({o_ded_cnt, o_log_syn, o_log_ded} !== {16'd1, 7'h07, 1'b0})
      $display("FAIL double_cnt_log: ded_cnt=%0d log_syn=%h log_ded=%b, required 1/07/0", o_ded_cnt, o_log_syn, o_log_ded);
    else n_pass++;
  endtask

  task automatic test_check_bit();
    int lat;
    logic [31:0] d;
    d = $urandom;
    send({1'b0, enc(d) ^ 7'h08, d}, 1'b1);
    wait_out(lat);
    n_checks++;
    if ({o_data, o_syn, o_sec, o_ded} !== {d, 7'h08, 2'b10})
      $display("FAIL check_bit3: data=%h syn=%h sec=%b ded=%b, required %h/08/1/0", o_data, o_syn, o_sec, o_ded, d);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (o_sec_cnt !== 16'd2) $display("FAIL check_bit_cnt: sec_cnt=%0d, required 2", o_sec_cnt);
    else n_pass++;
  endtask

  task automatic test_corr_en();
    int lat, j;
    logic [31:0] d;
    logic [39:0] w;
    d = $urandom;
    j = $urandom_range(0, 31);
    w = {1'b1, enc(d), d};
    w[j] = ~w[j];
    for (int c = 0; c < 2; c++) begin
      send(w, c[0]);
      wait_out(lat);
      n_checks++;
      if ({o_data, o_tag, o_syn, o_sec, o_ded} !== {(c == 1) ? d : w[31:0], 1'b1, HCOL[j], 2'b10})
        $display("FAIL corr_en=%0d bit%0d: data=%h tag=%b syn=%h sec=%b, required data=%h tag=1 syn=%h sec=1",
                 c, j, o_data, o_tag, o_syn, o_sec, (c == 1) ? d : w[31:0], HCOL[j]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_log_clr();
    int lat;
    logic [31:0] d;
    logic [39:0] w1, w2;
    exp_t e;
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr = 1'b0;
    n_checks++;
    if (o_log_valid !== 1'b0) $display("FAIL log_clr: log_valid=%b, required 0", o_log_valid);
    else n_pass++;
    d = $urandom;
    w1 = {1'b0, enc(d), d}; w1[5] = ~w1[5];
    send(w1, 1'b1); wait_out(lat);
    @(posedge clk); #1;
    n_checks++;
    if ({o_log_valid, o_log_syn, o_log_ded, o_log_word} !== {1'b1, HCOL[5], 1'b0, w1})
      $display("FAIL log_capture: valid=%b syn=%h ded=%b word=%h, required 1/%h/0/%h",
               o_log_valid, o_log_syn, o_log_ded, o_log_word, HCOL[5], w1);
    else n_pass++;
    w2 = {1'b1, enc(d), d}; w2[7] = ~w2[7]; w2[20] = ~w2[20];
    e = model(w2, 1'b1);
    send(w2, 1'b1); wait_out(lat);
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr = 1'b0;
    n_checks++;
    if ({o_log_valid, o_log_syn, o_log_ded, o_log_word} !== {1'b1, e.syn, 1'b1, w2})
      $display("FAIL log_clr_capture: valid=%b syn=%h ded=%b word=%h, required 1/%h/1/%h",
               o_log_valid, o_log_syn, o_log_ded, o_log_word, e.syn, w2);
    else n_pass++;
  endtask

  task automatic test_cnt_clr();
    int lat;
    send(40'h4, 1'b1); wait_out(lat);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++;
    if ({o_sec_cnt, o_ded_cnt} !== 32'd0)
      $display("FAIL cnt_clr_priority: sec_cnt=%0d ded_cnt=%0d, required 0/0", o_sec_cnt, o_ded_cnt);
    else n_pass++;
    send(40'h4, 1'b1); wait_out(lat);
    @(posedge clk); #1;
    n_checks++;
    if (o_sec_cnt !== 16'd1) $display("FAIL cnt_after_clr: sec_cnt=%0d, required 1", o_sec_cnt);
    else n_pass++;
  endtask

  task automatic test_throughput();
    int fires;
    fires = 0;
    sel = 1'b0; out_ready = 1'b1; in_valid = 1'b1; corr_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_word = rand_word();
      @(negedge clk);
      if (o_in_ready) fires++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (fires != 20) $display("FAIL throughput: %0d transfers in 20 cycles, required 20", fires);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back(input logic s, input int n_words, input bit toggle);
    exp_t        q[$];
    exp_t        e;
    logic [41:0] prev, cur;
    int          sent, got, cyc;
    bit          stalled;
    sent = 0; got = 0; cyc = 0; stalled = 0; prev = '0;
    sel = s;
    in_word = rand_word(); corr_en = $urandom_range(0, 1) != 0;
    in_valid = 1'b1; out_ready = 1'b0;
    while (got < n_words && cyc < 2000) begin
      @(negedge clk);
      cur = {o_data, o_tag, o_syn, o_sec, o_ded};
      if (stalled) begin
        n_checks++;
        if (!o_valid || cur !== prev)
          $display("FAIL stall_stable: valid=%b out=%h, required 1/%h", o_valid, cur, prev);
        else n_pass++;
      end
      if (o_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL burst_extra: out=%h with no word pending, required none", cur);
        else begin
          e = q.pop_front();
          if (cur !== {e.data, e.tag, e.syn, e.sec, e.ded})
            $display("FAIL burst_word%0d: out=%h, required %h", got, cur, {e.data, e.tag, e.syn, e.sec, e.ded});
          else n_pass++;
        end
        got++;
      end
      stalled = o_valid && !out_ready;
      prev = cur;
      if (in_valid && o_in_ready) begin
        q.push_back(model(in_word, corr_en));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      in_valid = (sent < n_words) && ($urandom_range(0, 3) != 0);
      in_word  = rand_word();
      corr_en  = $urandom_range(0, 1) != 0;
      out_ready = toggle ? ~out_ready : ($urandom_range(0, 1) != 0);
    end
    n_checks++;
    if (got != n_words || q.size() != 0)
      $display("FAIL burst_count: got %0d words (%0d pending), required %0d", got, q.size(), n_words);
    else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_pipe1_latency();
    int lat;
    exp_t e;
    logic [39:0] w;
    sel = 1'b1;
    w = 40'h80_0000_0000; w[31] = 1'b1;
    e = model(w, 1'b1);
    send(w, 1'b1);
    wait_out(lat);
    n_checks++;
    if (lat != 2) $display("FAIL pipe1_latency: got %0d cycles, required 2", lat);
    else n_pass++;
    n_checks++;
    if ({o_data, o_tag, o_syn, o_sec, o_ded} !== {32'h0, 1'b1, 7'h34, 2'b10} || e.syn != 7'h34)
      $display("FAIL pipe1_bit31: data=%h tag=%b syn=%h sec=%b, required 0/1/34/1", o_data, o_tag, o_syn, o_sec);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int lat;
    sel = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(40'h10, 1'b1); wait_out(lat);
      @(posedge clk); #1;
    end
    n_checks++;
    if (o_sec_cnt !== 16'd3) $display("FAIL saturate: sec_cnt=%0d, required 3", o_sec_cnt);
    else n_pass++;
  endtask

  task automatic test_rst_inflight();
    int seen;
    seen = 0;
    sel = 1'b1; out_ready = 1'b0;
    send(40'h1, 1'b1);
    send(40'h2, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_in_ready} !== 2'b00)
      $display("FAIL rst_inflight: out_valid=%b in_ready=%b, required 0/0", o_valid, o_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_in_ready !== 1'b1) $display("FAIL rst_ready_rise: in_ready=%b, required 1", o_in_ready);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (o_valid) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) $display("FAIL rst_stale: out_valid seen %0d cycles, required 0", seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_check_bit();
    test_corr_en();
    test_log_clr();
    test_cnt_clr();
    test_throughput();
    test_back_to_back(1'b0, 8, 1'b1);
    test_back_to_back(1'b0, 150, 1'b0);
    test_pipe1_latency();
    test_back_to_back(1'b1, 150, 1'b0);
    test_saturate();
    test_rst_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ecc_secded_dec_pipe.md
ECC_SECDED_DEC_PIPE -- requirements
Module: ecc_secded_dec_pipe

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 Parameter DATA_W, default 32: data bits per codeword.
REQ-003 Parameter CHK_W, default 7: check bits per codeword.
REQ-004 Parameter H_COLS, DATA_W*CHK_W bits, default = team (39,32) Hsiao table:
  - column for data bit i at [i*CHK_W +: CHK_W];
  - bit 0 = 7'b0000111, bit 31 = 7'b0110100;
  - check bit k column = one-hot k.
REQ-005 Parameter PIPE, default 0: 0 = one register stage; 1 = added syndrome register stage.
REQ-006 Parameter CNT_W, default 16: error counter width.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 in_word  in  DATA_W+CHK_W+1  codeword:
  - [DATA_W-1:0] data;
  - [DATA_W+CHK_W-1:DATA_W] check;
  - MSB tag, passed through unchanged.
REQ-010 in_valid  in  1; in_ready  out  1: input handshake.
REQ-011 corr_en  in  1: 1 = correct single errors; 0 = flag only, raw data out.
REQ-012 out_data  out  DATA_W; out_tag  out  1; out_syn  out  CHK_W.
REQ-013 out_sec  out  1 (single error); out_ded  out  1 (uncorrectable).
REQ-014 out_valid  out  1; out_ready  in  1: output handshake.
REQ-015 cnt_clr  in  1; sec_cnt  out  CNT_W; ded_cnt  out  CNT_W.
REQ-016 log_clr  in  1; log_valid  out  1; log_syn  out  CHK_W; log_ded  out  1; log_word  out  DATA_W+CHK_W+1.

Function
REQ-017 Syndrome bit k SHALL equal the XOR of:
  - each data bit i whose H_COLS column has bit k set;
  - check bit k.
REQ-018 Classification:
  - syn==0 -> clean;
  - syn equals exactly one data or check column -> out_sec=1;
  - any other nonzero syn -> out_ded=1.
REQ-019 On sec with corr_en=1, the matching data bit SHALL be inverted; on a check-bit match, data is unchanged.
REQ-020 On ded, or when corr_en=0, out_data SHALL equal the raw input data.
REQ-021 corr_en SHALL be sampled with in_word on the input transfer.
REQ-022 Transfers SHALL occur on clock edges where valid and ready are both high.
REQ-023 Latency from input transfer to out_valid SHALL be 1 cycle for PIPE=0 and 2 cycles for PIPE=1.
REQ-024 Each stage SHALL load when empty or when its downstream stage advances.
REQ-025 in_ready SHALL be combinational: first stage empty, or first stage advancing this cycle.
REQ-026 Full throughput of one word per cycle SHALL be sustained while out_ready=1.
REQ-027 While out_valid=1 and out_ready=0, all out_* SHALL hold stable; no word is dropped or duplicated.
REQ-028 Counters SHALL increment by 1 on each output transfer carrying sec (sec_cnt) or ded (ded_cnt).
REQ-029 Counters SHALL saturate at all-ones.
REQ-030 cnt_clr SHALL zero both counters next cycle and take priority over a simultaneous increment.
REQ-031 Error log capture:
  - on the first output transfer with sec or ded while log_valid=0: capture syndrome, ded flag and raw in_word; set log_valid;
  - later errors SHALL NOT overwrite the log.
REQ-032 log_clr SHALL clear log_valid; log_clr coinciding with an error transfer SHALL capture that error instead.
REQ-033 The tag bit SHALL be ignored by syndrome, classification and correction.

Reset
REQ-034 While rst=1:
  - pipeline stages empty;
  - out_valid=0 and in_ready=0;
  - out_data, out_tag, out_syn, out_sec and out_ded = 0;
  - counters = 0;
  - log_valid, log_syn, log_ded and log_word = 0.
REQ-035 Assertion of rst mid-transfer SHALL discard all in-flight words.
REQ-036 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-037 Defaults, all-zero word -> out_data=0, syn=0, sec=0, ded=0, one cycle later.
REQ-038 All-zero word with data bit 0 flipped, corr_en=1 -> syn=7'h07, out_data=0, sec=1, sec_cnt=1, log_syn=7'h07.
REQ-039 Data bits 0 and 1 flipped -> syn=7'h0C, ded=1, out_data=32'h3, ded_cnt increments.
REQ-040 Check bit 3 flipped -> syn=7'h08, sec=1, out_data unchanged.
REQ-041 Handshake and overflow:
  - 8-word burst with out_ready toggling -> all 8 words in order, outputs stable while stalled;
  - CNT_W=2 with 5 sec words -> sec_cnt=3.
REQ-042 rst pulsed with 2 words in flight (PIPE=1) -> out_valid=0 immediately; no stale word after release.
